// File: rtl/vector_square.sv
`default_nettype none
// ============================================================================
//  Module      : vector_square
//  Description : Two-lane pipelined floating-point squarer. Each accepted
//                operand pair (data_1, data_2) yields (square_1, square_2)
//                exactly two cycles later. The two lanes share one valid
//                flag and never interact.
//
//  Float format: [WIDTH-1] sign | [WIDTH-2 -: EXP_W] exponent (bias
//                2^(EXP_W-1)-1) | [MAN_W-1:0] fraction with a hidden 1.
//                Denormal inputs are flushed to zero. No denormals are
//                produced. The result sign is always 0.
//
//  Ports       : clk        rising-edge clock
//                rst_n      synchronous active-low reset
//                in_valid   data_1/data_2 valid this cycle
//                data_1     lane 1 operand  (WIDTH)
//                data_2     lane 2 operand  (WIDTH)
//                out_valid  square_1/square_2 valid
//                square_1   lane 1 result   (WIDTH), holds while out_valid=0
//                square_2   lane 2 result   (WIDTH), holds while out_valid=0
//
//  Option      : SQUARE_ROUND_EN defined   -> round-to-nearest-even
//                SQUARE_ROUND_EN undefined -> truncate toward zero
//                The latency is the same in both builds.
//
//  Revision    : 1.0  initial release
// ============================================================================
module vector_square #(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    output logic [WIDTH-1:0] square_1,
    output logic [WIDTH-1:0] square_2
);

    localparam int MAN_W = WIDTH - 1 - EXP_W;
    localparam int c_MW1 = MAN_W + 1;      // mantissa with hidden 1
    localparam int c_PW  = 2 * c_MW1;      // full product width
    localparam int c_EW  = EXP_W + 2;      // holds -bias .. 2*(2^EXP_W-1)+1

    localparam logic        [c_EW-1:0]  c_BIAS = c_EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_EW-1:0]  c_EMAX = c_EW'((1 << EXP_W) - 1);
    localparam logic        [WIDTH-1:0] c_INF  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    // r_in  : operand register at the block boundary, so the multiplier
    //         starts from a clean flop instead of register-read timing.
    // r_p.. : stage 1 product, doubled exponent and special-case flags.
    // r_sq  : result register, loaded only for valid results.
    logic                    r_v0;
    logic                    r_v1;
    logic                    r_out_valid;
    logic [WIDTH-2:0]        r_in   [0:1];
    logic [c_PW-1:0]         r_p    [0:1];
    logic signed [c_EW-1:0]  r_e2   [0:1];
    logic                    r_inf  [0:1];
    logic                    r_zero [0:1];
    logic [WIDTH-1:0]        r_sq   [0:1];

    // Per-lane combinational results
    logic [WIDTH-2:0]        w_din  [0:1];
    logic [c_PW-1:0]         w_p    [0:1];
    logic signed [c_EW-1:0]  w_e2   [0:1];
    logic                    w_inf  [0:1];
    logic                    w_zero [0:1];
    logic [WIDTH-1:0]        w_res  [0:1];

    // Operand signs never affect a square.
    logic w_unused_sign;
    assign w_unused_sign = data_1[WIDTH-1] ^ data_2[WIDTH-1];

    assign w_din[0] = data_1[WIDTH-2:0];
    assign w_din[1] = data_2[WIDTH-2:0];

    // ------------------------------------------------------------------
    // Sequential pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_out_valid <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                r_in[l]   <= '0;
                r_p[l]    <= '0;
                r_e2[l]   <= '0;
                r_inf[l]  <= 1'b0;
                r_zero[l] <= 1'b0;
                r_sq[l]   <= '0;
            end
        end else begin
            r_v0        <= in_valid;
            r_v1        <= r_v0;
            r_out_valid <= r_v1;
            for (int l = 0; l < 2; l++) begin
                if (in_valid) begin
                    r_in[l] <= w_din[l];
                end
                if (r_v0) begin
                    r_p[l]    <= w_p[l];
                    r_e2[l]   <= w_e2[l];
                    r_inf[l]  <= w_inf[l];
                    r_zero[l] <= w_zero[l];
                end
                if (r_v1) begin
                    r_sq[l] <= w_res[l];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    for (genvar gl = 0; gl < 2; gl++) begin : g_lane
        // ---------------- stage 1: decode and multiply ----------------
        logic [EXP_W-1:0] w_e;
        logic [MAN_W-1:0] w_f;
        logic [c_MW1-1:0] w_m;

        assign w_e = r_in[gl][WIDTH-2 -: EXP_W];
        assign w_f = r_in[gl][MAN_W-1:0];
        assign w_m = {1'b1, w_f};

        assign w_p[gl]    = c_PW'(w_m) * c_PW'(w_m);
        // 2e - bias; {0,e,0} is 2e already zero-extended to c_EW bits.
        assign w_e2[gl]   = $signed({1'b0, w_e, 1'b0} - c_BIAS);
        assign w_inf[gl]  = &w_e;
        assign w_zero[gl] = ~|w_e;

        // ---------------- stage 2: normalise, round, classify ---------
        logic                   w_top;
        logic [MAN_W-1:0]       w_frac_t;
        logic signed [c_EW-1:0] w_exp_n;
        logic [MAN_W-1:0]       w_frac_r;
        logic signed [c_EW-1:0] w_exp_r;
        logic                   w_ovf;
        logic                   w_unf;
        logic [WIDTH-1:0]       w_lane_res;

        // Product of two [1,2) mantissas lies in [1,4): the leading 1 is
        // either at the MSB (value >= 2, bump exponent) or one below it.
        assign w_top    = r_p[gl][c_PW-1];
        assign w_frac_t = w_top ? r_p[gl][c_PW-2 -: MAN_W]
                                : r_p[gl][c_PW-3 -: MAN_W];
        assign w_exp_n  = r_e2[gl] + {{(c_EW-1){1'b0}}, w_top};

`ifdef SQUARE_ROUND_EN
        logic             w_guard;
        logic             w_sticky;
        logic             w_round;
        logic [MAN_W:0]   w_sum;

        assign w_guard  = w_top ? r_p[gl][c_PW-2-MAN_W] : r_p[gl][c_PW-3-MAN_W];
        assign w_sticky = w_top ? (|r_p[gl][c_PW-3-MAN_W:0])
                                : (|r_p[gl][c_PW-4-MAN_W:0]);
        // Round up above half, or on an exact half when the LSB is odd.
        assign w_round  = w_guard & (w_sticky | w_frac_t[0]);
        assign w_sum    = {1'b0, w_frac_t} + {{MAN_W{1'b0}}, w_round};
        // A carry out of the fraction means the mantissa became 2.0.
        assign w_frac_r = w_sum[MAN_W] ? '0 : w_sum[MAN_W-1:0];
        assign w_exp_r  = w_exp_n + {{(c_EW-1){1'b0}}, w_sum[MAN_W]};
`else
        logic w_unused_low;

        assign w_unused_low = ^r_p[gl][c_PW-3-MAN_W:0];
        assign w_frac_r     = w_frac_t;
        assign w_exp_r      = w_exp_n;
`endif

        assign w_ovf = (w_exp_r >= c_EMAX);
        assign w_unf = w_exp_r[c_EW-1] | (w_exp_r == '0);

        always_comb begin
            w_lane_res = {1'b0, w_exp_r[EXP_W-1:0], w_frac_r};
            if (r_inf[gl]) begin
                w_lane_res = c_INF;
            end else if (r_zero[gl]) begin
                w_lane_res = '0;
            end else if (w_ovf) begin
                w_lane_res = c_INF;
            end else if (w_unf) begin
                w_lane_res = '0;
            end
        end

        assign w_res[gl] = w_lane_res;
    end

    assign out_valid = r_out_valid;
    assign square_1  = r_sq[0];
    assign square_2  = r_sq[1];

endmodule
`default_nettype wire

// File: tb/tb_vector_square.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_square
//  Description : Directed self-checking bench for vector_square. Expected
//                values are hand-computed 24-bit floats (8-bit exponent,
//                15-bit fraction). Inputs change 1 time unit after a rising
//                edge and outputs are sampled at the same offset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_square;

    localparam int WIDTH = 24;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic             out_valid;
    logic [WIDTH-1:0] square_1;
    logic [WIDTH-1:0] square_2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_square #(
        .WIDTH (WIDTH),
        .EXP_W (EXP_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_1    (data_1),
        .data_2    (data_2),
        .out_valid (out_valid),
        .square_1  (square_1),
        .square_2  (square_2)
    );

`ifdef SQUARE_ROUND_EN
    localparam logic [WIDTH-1:0] c_RND_EXP = 24'h3F8103;
`else
    localparam logic [WIDTH-1:0] c_RND_EXP = 24'h3F8102;
`endif

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for a single cycle, check exact 2-cycle latency,
    // then check that the results hold once out_valid drops.
    task automatic run_pair(input string tag,
                            input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                            input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
        in_valid = 1'b1;
        data_1   = d1;
        data_2   = d2;
        tick();                           // captured at this edge
        in_valid = 1'b0;
        data_1   = 24'h5A5A5A;            // junk while idle, must be ignored
        data_2   = 24'hA5A5A5;
        tick();
        chk({tag, "_early_v"}, {23'b0, out_valid}, 24'h0);
        tick();
        chk({tag, "_v"},  {23'b0, out_valid}, 24'h1);
        chk({tag, "_s1"}, square_1, e1);
        chk({tag, "_s2"}, square_2, e2);
        tick();
        chk({tag, "_idle_v"},  {23'b0, out_valid}, 24'h0);
        chk({tag, "_hold_s1"}, square_1, e1);
        chk({tag, "_hold_s2"}, square_2, e2);
    endtask

    initial begin
        // ---------------- reset with in_valid held high ----------------
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_1   = 24'h3F8000;
        data_2   = 24'hBF8000;
        tick();
        tick();
        chk("rst_v",  {23'b0, out_valid}, 24'h0);
        chk("rst_s1", square_1, 24'h000000);
        chk("rst_s2", square_2, 24'h000000);

        // Release reset; the pair present at the next edge is the first.
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_early_v", {23'b0, out_valid}, 24'h0);
        tick();
        chk("post_rst_v",  {23'b0, out_valid}, 24'h1);
        chk("post_rst_s1", square_1, 24'h3F8000);
        chk("post_rst_s2", square_2, 24'h3F8000);
        tick();

        // ---------------- directed vectors ----------------
        run_pair("basic", 24'h3F8000, 24'hBF8000, 24'h3F8000, 24'h3F8000);
        run_pair("norm",  24'h3FC000, 24'h400000, 24'h401000, 24'h408000);
        run_pair("round", 24'h3F8081, 24'h408000, c_RND_EXP,  24'h418000);
        run_pair("ovf_unf", 24'h780000, 24'h080000, 24'h7F8000, 24'h000000);
        run_pair("zero",  24'h000000, 24'h3FC000, 24'h000000, 24'h401000);
        run_pair("inf_nan", 24'h7F8000, 24'hFFC000, 24'h7F8000, 24'h7F8000);
        run_pair("denorm", 24'h004000, 24'hC00000, 24'h000000, 24'h408000);

        // ---------------- back-to-back throughput ----------------
        in_valid = 1'b1;
        data_1 = 24'h3F8000; data_2 = 24'h400000;
        tick();
        data_1 = 24'h3FC000; data_2 = 24'h3F8000;
        tick();
        chk("tp_early_v", {23'b0, out_valid}, 24'h0);
        data_1 = 24'h400000; data_2 = 24'h3FC000;
        tick();
        in_valid = 1'b0;
        data_1 = 24'h123456; data_2 = 24'h654321;
        chk("tp0_v",  {23'b0, out_valid}, 24'h1);
        chk("tp0_s1", square_1, 24'h3F8000);
        chk("tp0_s2", square_2, 24'h408000);
        tick();
        chk("tp1_v",  {23'b0, out_valid}, 24'h1);
        chk("tp1_s1", square_1, 24'h401000);
        chk("tp1_s2", square_2, 24'h3F8000);
        tick();
        chk("tp2_v",  {23'b0, out_valid}, 24'h1);
        chk("tp2_s1", square_1, 24'h408000);
        chk("tp2_s2", square_2, 24'h401000);
        tick();
        chk("tp_end_v",  {23'b0, out_valid}, 24'h0);
        chk("tp_hold_s1", square_1, 24'h408000);
        chk("tp_hold_s2", square_2, 24'h401000);
        tick();
        chk("tp_end2_v", {23'b0, out_valid}, 24'h0);

        // ---------------- reset discards in-flight data ----------------
        in_valid = 1'b1;
        data_1 = 24'h3FC000; data_2 = 24'h3FC000;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("flush_v",  {23'b0, out_valid}, 24'h0);
        chk("flush_s1", square_1, 24'h000000);
        tick();
        chk("flush2_v", {23'b0, out_valid}, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
